// File: rtl/spi_accel_responder_if.sv
// SPI pin bundle between the command handler's SPI master and the accelerometer model.
// The master drives clock, chip select and MOSI; the responder drives MISO.
interface spi_accel_responder_if;
  logic i_SPI_Clk;
  logic i_SPI_CSLow;
  logic i_SPI_Mosi;
  logic o_SPI_Miso;

  modport master (
    output i_SPI_Clk,
    output i_SPI_CSLow,
    output i_SPI_Mosi,
    input  o_SPI_Miso
  );

  modport slave (
    input  i_SPI_Clk,
    input  i_SPI_CSLow,
    input  i_SPI_Mosi,
    output o_SPI_Miso
  );
endinterface

// File: rtl/spi_accel_responder.sv
// Mode-0 SPI slave modelling the accelerometer register file, oversampled in the clk domain.
// Decodes instruction/address/data bytes, commits writes, and streams register contents on reads.
module spi_accel_responder #(
  parameter int unsigned CMDLENGTH   = 8,
  parameter int unsigned REG_COUNT   = 64,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  spi_accel_responder_if.slave spi,
  input  logic [CMDLENGTH-1:0] i_Peek_Addr,
  output logic [CMDLENGTH-1:0] o_Peek_Data,
  output logic                 o_Reg_WriteStrobe,
  output logic [CMDLENGTH-1:0] o_Reg_WriteAddr,
  output logic [CMDLENGTH-1:0] o_Reg_WriteData,
  output logic                 o_Busy,
  output logic                 o_Cmd_Error
);

  localparam int unsigned AW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
  localparam int unsigned BW = $clog2(CMDLENGTH);
  localparam logic [BW-1:0]        LP_LAST_BIT  = BW'(CMDLENGTH - 1);
  localparam logic [CMDLENGTH:0]   LP_REG_LIMIT = (CMDLENGTH + 1)'(REG_COUNT);
  localparam logic [CMDLENGTH-1:0] LP_CMD_WRITE = CMDLENGTH'(8'h0A);
  localparam logic [CMDLENGTH-1:0] LP_CMD_READ  = CMDLENGTH'(8'h0B);
  localparam logic [CMDLENGTH-1:0] LP_RO_LIMIT  = CMDLENGTH'(8'h03);
  localparam logic [CMDLENGTH-1:0] LP_SOFT_ADDR = CMDLENGTH'(8'h1F);
  localparam logic [CMDLENGTH-1:0] LP_SOFT_DATA = CMDLENGTH'(8'h52);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INSTR,
    S_ADDR,
    S_DATA,
    S_IGNORE
  } state_t;

  state_t                r_state;
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_flush;
  logic                  r_sclk_prev;
  logic                  r_cs_prev;
  logic                  r_armed;
  logic [BW-1:0]         r_bit_cnt;
  logic [CMDLENGTH-2:0]  r_shift;
  logic [CMDLENGTH-1:0]  r_miso_shift;
  logic [CMDLENGTH-1:0]  r_ptr;
  logic                  r_is_read;
  logic                  r_miso;
  logic                  r_cmd_error;
  logic                  r_strobe;
  logic [CMDLENGTH-1:0]  r_waddr;
  logic [CMDLENGTH-1:0]  r_wdata;
  logic                  r_soft_rst;
  logic [CMDLENGTH-1:0]  r_peek_data;
  logic [CMDLENGTH-1:0]  r_regs [REG_COUNT];

  logic                  w_sclk;
  logic                  w_cs;
  logic                  w_mosi;
  logic                  w_sclk_rise;
  logic                  w_sclk_fall;
  logic                  w_cs_rise;
  logic                  w_cs_fall;
  logic                  w_byte_last;
  logic [CMDLENGTH-1:0]  w_byte;
  logic [CMDLENGTH-1:0]  w_ptr_next;
  logic                  w_ptr_writable;
  logic                  w_wr_ok;
  logic                  w_soft;
  logic                  w_reg_we;

  function automatic logic [CMDLENGTH-1:0] f_reset_val(input int unsigned idx);
    if (idx == 0)      return CMDLENGTH'(8'hAD);
    else if (idx == 1) return CMDLENGTH'(8'h1D);
    else if (idx == 2) return CMDLENGTH'(8'hF2);
    else               return '0;
  endfunction

  function automatic logic [CMDLENGTH-1:0] f_rd(input logic [CMDLENGTH-1:0] a);
    if ({1'b0, a} < LP_REG_LIMIT) return r_regs[a[AW-1:0]];
    else                          return '0;
  endfunction

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs        = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk & ~r_sclk_prev;
  assign w_sclk_fall = ~w_sclk & r_sclk_prev;
  assign w_cs_rise   = w_cs & ~r_cs_prev;
  // A fall only counts once CS has been seen high on a real sample, so a
  // reset released mid-transaction waits for a fresh select.
  assign w_cs_fall   = ~w_cs & r_cs_prev & r_armed;

  assign w_byte         = {r_shift, w_mosi};
  assign w_byte_last    = w_sclk_rise & (r_bit_cnt == LP_LAST_BIT) & ~w_cs_rise & ~w_cs_fall;
  assign w_ptr_next     = r_ptr + 1'b1;
  assign w_ptr_writable = ({1'b0, r_ptr} < LP_REG_LIMIT) && (r_ptr >= LP_RO_LIMIT);
  assign w_wr_ok        = (r_state == S_DATA) & ~r_is_read & w_byte_last & w_ptr_writable;
  assign w_soft         = w_wr_ok & (r_ptr == LP_SOFT_ADDR) & (w_byte == LP_SOFT_DATA);
  assign w_reg_we       = w_wr_ok & ~w_soft;

  assign spi.o_SPI_Miso    = r_miso;
  assign o_Peek_Data       = r_peek_data;
  assign o_Reg_WriteStrobe = r_strobe;
  assign o_Reg_WriteAddr   = r_waddr;
  assign o_Reg_WriteData   = r_wdata;
  assign o_Busy            = ~w_cs;
  assign o_Cmd_Error       = r_cmd_error;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_flush     <= '0;
      r_sclk_prev <= 1'b0;
      r_cs_prev   <= 1'b1;
      r_armed     <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi.i_SPI_Clk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi.i_SPI_CSLow};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi.i_SPI_Mosi};
      r_flush     <= {r_flush[SYNC_STAGES-2:0], 1'b1};
      r_sclk_prev <= w_sclk;
      r_cs_prev   <= w_cs;
      r_armed     <= r_armed | (r_flush[SYNC_STAGES-1] & w_cs);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_miso_shift <= '0;
      r_ptr        <= '0;
      r_is_read    <= 1'b0;
      r_miso       <= 1'b0;
      r_cmd_error  <= 1'b0;
      r_strobe     <= 1'b0;
      r_waddr      <= '0;
      r_wdata      <= '0;
      r_soft_rst   <= 1'b0;
    end else begin
      r_strobe   <= 1'b0;
      r_soft_rst <= w_soft;
      if (w_cs_rise) begin
        r_state <= S_IDLE;
        r_miso  <= 1'b0;
      end else if (w_cs_fall) begin
        r_state     <= S_INSTR;
        r_bit_cnt   <= '0;
        r_cmd_error <= 1'b0;
        r_miso      <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: r_miso <= 1'b0;
          S_INSTR: begin
            r_miso <= 1'b0;
            if (w_sclk_rise) begin
              r_shift   <= w_byte[CMDLENGTH-2:0];
              r_bit_cnt <= r_bit_cnt + 1'b1;
              if (w_byte_last) begin
                if (w_byte == LP_CMD_WRITE) begin
                  r_is_read <= 1'b0;
                  r_state   <= S_ADDR;
                end else if (w_byte == LP_CMD_READ) begin
                  r_is_read <= 1'b1;
                  r_state   <= S_ADDR;
                end else begin
                  r_cmd_error <= 1'b1;
                  r_state     <= S_IGNORE;
                end
              end
            end
          end
          S_ADDR: begin
            r_miso <= 1'b0;
            if (w_sclk_rise) begin
              r_shift   <= w_byte[CMDLENGTH-2:0];
              r_bit_cnt <= r_bit_cnt + 1'b1;
              if (w_byte_last) begin
                r_ptr        <= w_byte;
                r_miso_shift <= f_rd(w_byte);
                r_state      <= S_DATA;
              end
            end
          end
          S_DATA: begin
            if (w_sclk_rise) begin
              r_shift   <= w_byte[CMDLENGTH-2:0];
              r_bit_cnt <= r_bit_cnt + 1'b1;
              if (w_byte_last) begin
                r_ptr <= w_ptr_next;
                if (r_is_read) r_miso_shift <= f_rd(w_ptr_next);
                if (w_wr_ok) begin
                  r_strobe <= 1'b1;
                  r_waddr  <= r_ptr;
                  r_wdata  <= w_byte;
                end
              end
            end else if (w_sclk_fall && r_is_read) begin
              r_miso       <= r_miso_shift[CMDLENGTH-1];
              r_miso_shift <= {r_miso_shift[CMDLENGTH-2:0], 1'b0};
            end
            if (!r_is_read) r_miso <= 1'b0;
          end
          S_IGNORE: r_miso <= 1'b0;
          default: begin
            r_state <= S_IDLE;
            r_miso  <= 1'b0;
          end
        endcase
      end
    end
  end

  // The soft-reset command byte itself is not stored, so 0x1F never reads back 0x52.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) r_regs[i] <= f_reset_val(i);
    end else if (r_soft_rst) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) r_regs[i] <= f_reset_val(i);
    end else if (w_reg_we) begin
      r_regs[r_ptr[AW-1:0]] <= w_byte;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_peek_data <= '0;
    else        r_peek_data <= f_rd(i_Peek_Addr);
  end

endmodule

// File: tb/tb_spi_accel_responder.sv
// Directed bench for spi_accel_responder: bit-banged mode-0 master with hand-computed expectations.
module tb_spi_accel_responder;
  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] peek_addr;
  logic [7:0] peek_data;
  logic       strobe;
  logic [7:0] waddr;
  logic [7:0] wdata;
  logic       busy;
  logic       cerr;

  int vectors     = 0;
  int miscompares = 0;
  int strobe_cnt  = 0;

  always #5 clk = ~clk;

  spi_accel_responder_if bus ();

  spi_accel_responder #(
    .CMDLENGTH  (8),
    .REG_COUNT  (64),
    .SYNC_STAGES(2)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .spi              (bus),
    .i_Peek_Addr      (peek_addr),
    .o_Peek_Data      (peek_data),
    .o_Reg_WriteStrobe(strobe),
    .o_Reg_WriteAddr  (waddr),
    .o_Reg_WriteData  (wdata),
    .o_Busy           (busy),
    .o_Cmd_Error      (cerr)
  );

  always @(posedge clk) if (strobe) strobe_cnt <= strobe_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_low();
    bus.i_SPI_CSLow = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic cs_high();
    wait_clk(HALF);
    bus.i_SPI_CSLow = 1'b1;
    wait_clk(HALF);
  endtask

  task automatic xfer_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      bus.i_SPI_Mosi = tx[i];
      wait_clk(HALF);
      rx[i] = bus.o_SPI_Miso;
      bus.i_SPI_Clk = 1'b1;
      wait_clk(HALF);
      bus.i_SPI_Clk = 1'b0;
    end
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    xfer_bits(tx, 8, rx);
  endtask

  task automatic peek(input string tag, input logic [7:0] a, input logic [7:0] exp);
    peek_addr = a;
    wait_clk(2);
    check(tag, {24'd0, peek_data}, {24'd0, exp});
  endtask

  task automatic spi_write(input logic [7:0] a, input logic [7:0] d);
    logic [7:0] rx;
    cs_low();
    xfer(8'h0A, rx);
    xfer(a, rx);
    xfer(d, rx);
    cs_high();
  endtask

  initial begin
    logic [7:0] rx;
    reset = 1'b0;
    bus.i_SPI_Clk = 1'b0;
    bus.i_SPI_CSLow = 1'b1;
    bus.i_SPI_Mosi = 1'b0;
    peek_addr = 8'h00;
    wait_clk(4);
    check("rst_miso",   {31'd0, bus.o_SPI_Miso}, 32'd0);
    check("rst_peek",   {24'd0, peek_data}, 32'd0);
    check("rst_strobe", {31'd0, strobe}, 32'd0);
    check("rst_waddr",  {24'd0, waddr}, 32'd0);
    check("rst_wdata",  {24'd0, wdata}, 32'd0);
    check("rst_busy",   {31'd0, busy}, 32'd0);
    check("rst_cerr",   {31'd0, cerr}, 32'd0);
    reset = 1'b1;
    wait_clk(4);
    peek("peek_r00", 8'h00, 8'hAD);
    peek("peek_r01", 8'h01, 8'h1D);
    peek("peek_r02", 8'h02, 8'hF2);
    peek("peek_r2d", 8'h2D, 8'h00);
    peek("peek_oor", 8'h40, 8'h00);

    // single read of 0x00
    cs_low();
    check("busy_cs_low", {31'd0, busy}, 32'd1);
    xfer(8'h0B, rx); check("rd_instr_miso", {24'd0, rx}, 32'd0);
    xfer(8'h00, rx); check("rd_addr_miso", {24'd0, rx}, 32'd0);
    xfer(8'h00, rx); check("rd_r00", {24'd0, rx}, 32'hAD);
    cs_high();
    check("rd_cerr", {31'd0, cerr}, 32'd0);
    check("rd_no_strobe", strobe_cnt, 32'd0);
    check("idle_miso", {31'd0, bus.o_SPI_Miso}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // write 0x2D=0x02, last bit driven by hand to check commit latency and peek ordering
    peek_addr = 8'h2D;
    cs_low();
    xfer(8'h0A, rx);
    xfer(8'h2D, rx);
    xfer_bits(8'h02, 7, rx);
    bus.i_SPI_Mosi = 1'b0;
    wait_clk(HALF);
    bus.i_SPI_Clk = 1'b1;
    wait_clk(3);
    check("wr_strobe_hi", {31'd0, strobe}, 32'd1);
    check("wr_waddr",     {24'd0, waddr}, 32'h2D);
    check("wr_wdata",     {24'd0, wdata}, 32'h02);
    check("wr_peek_old",  {24'd0, peek_data}, 32'h00);
    wait_clk(1);
    check("wr_strobe_lo", {31'd0, strobe}, 32'd0);
    check("wr_peek_new",  {24'd0, peek_data}, 32'h02);
    wait_clk(HALF - 4);
    bus.i_SPI_Clk = 1'b0;
    cs_high();
    check("wr_strobe_cnt", strobe_cnt, 32'd1);
    cs_low();
    xfer(8'h0B, rx); xfer(8'h2D, rx); xfer(8'h00, rx);
    check("rd_back_2d", {24'd0, rx}, 32'h02);
    cs_high();

    // burst read from 0x00
    cs_low();
    xfer(8'h0B, rx); xfer(8'h00, rx);
    xfer(8'h00, rx); check("burst_r0", {24'd0, rx}, 32'hAD);
    xfer(8'h00, rx); check("burst_r1", {24'd0, rx}, 32'h1D);
    xfer(8'h00, rx); check("burst_r2", {24'd0, rx}, 32'hF2);
    cs_high();

    // burst write across 0xFF -> 0x00: both ignored
    cs_low();
    xfer(8'h0A, rx); xfer(8'hFF, rx); xfer(8'h11, rx); xfer(8'h22, rx);
    cs_high();
    check("wrap_wr_no_strobe", strobe_cnt, 32'd1);
    peek("wrap_r00_kept", 8'h00, 8'hAD);
    cs_low();
    xfer(8'h0B, rx); xfer(8'hFF, rx);
    xfer(8'h00, rx); check("wrap_rd_ff", {24'd0, rx}, 32'h00);
    xfer(8'h00, rx); check("wrap_rd_00", {24'd0, rx}, 32'hAD);
    cs_high();

    // unknown instruction
    cs_low();
    xfer(8'h55, rx); check("bad_instr_miso", {24'd0, rx}, 32'd0);
    check("bad_cerr_set", {31'd0, cerr}, 32'd1);
    xfer(8'h0A, rx); check("bad_ign_miso0", {24'd0, rx}, 32'd0);
    xfer(8'h2D, rx); check("bad_ign_miso1", {24'd0, rx}, 32'd0);
    cs_high();
    check("bad_cerr_sticky", {31'd0, cerr}, 32'd1);
    check("bad_no_strobe", strobe_cnt, 32'd1);
    cs_low();
    check("bad_cerr_clear", {31'd0, cerr}, 32'd0);
    xfer(8'h0B, rx); xfer(8'h01, rx); xfer(8'h00, rx);
    check("after_bad_rd_r01", {24'd0, rx}, 32'h1D);
    cs_high();

    // aborted write leaves 0x2C alone
    spi_write(8'h2C, 8'h5A);
    check("wr2c_strobe_cnt", strobe_cnt, 32'd2);
    peek("wr2c_peek", 8'h2C, 8'h5A);
    cs_low();
    xfer(8'h0A, rx); xfer(8'h2C, rx);
    xfer_bits(8'hFF, 4, rx);
    cs_high();
    check("abort_no_strobe", strobe_cnt, 32'd2);
    peek("abort_2c_kept", 8'h2C, 8'h5A);

    // soft reset
    spi_write(8'h1F, 8'h52);
    check("soft_strobe_cnt", strobe_cnt, 32'd3);
    check("soft_waddr", {24'd0, waddr}, 32'h1F);
    check("soft_wdata", {24'd0, wdata}, 32'h52);
    peek("soft_2d", 8'h2D, 8'h00);
    peek("soft_2c", 8'h2C, 8'h00);
    peek("soft_1f", 8'h1F, 8'h00);
    peek("soft_00", 8'h00, 8'hAD);

    // reset in the middle of a write, CS held low across release
    cs_low();
    xfer(8'h0A, rx); xfer(8'h30, rx);
    reset = 1'b0;
    wait_clk(2);
    check("midrst_waddr", {24'd0, waddr}, 32'h00);
    check("midrst_wdata", {24'd0, wdata}, 32'h00);
    check("midrst_busy",  {31'd0, busy}, 32'd0);
    check("midrst_peek",  {24'd0, peek_data}, 32'h00);
    reset = 1'b1;
    wait_clk(4);
    check("midrst_busy_cs_low", {31'd0, busy}, 32'd1);
    xfer(8'h77, rx); check("midrst_miso", {24'd0, rx}, 32'd0);
    cs_high();
    check("midrst_no_strobe", strobe_cnt, 32'd3);
    peek("midrst_r30", 8'h30, 8'h00);
    cs_low();
    xfer(8'h0B, rx); xfer(8'h00, rx); xfer(8'h00, rx);
    check("midrst_fresh_rd", {24'd0, rx}, 32'hAD);
    cs_high();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/spi_accel_responder.md
# spi_accel_responder

SPI slave that models the accelerometer's register interface at the far end of the SPI link driven by the command handler/SPI master. It decodes the instruction/address/data byte sequence on MOSI, commits writes into an internal byte-wide register file, and returns register contents on MISO for reads. It runs entirely in the system clock domain by oversampling the SPI pins. It serves as the in-fabric loop-back target for bring-up and as the device model in simulation.

## Interface
- CMDLENGTH, 8, bits per SPI byte; instruction, address and data are all this width
- REG_COUNT, 64, implemented registers at addresses 0..REG_COUNT-1
- SYNC_STAGES, 2, flip-flop stages on each SPI input before edge detection
- clk  in  1  system clock; must run at least 4x the SPI clock
- reset  in  1  asynchronous, active-low reset
- i_SPI_Clk  in  1  SPI clock from master, mode 0 (idles low)
- i_SPI_CSLow  in  1  chip select, active low
- i_SPI_Mosi  in  1  serial data from master, MSB first
- o_SPI_Miso  out  1  serial data to master, MSB first
- i_Peek_Addr  in  CMDLENGTH  host-side register read address
- o_Peek_Data  out  CMDLENGTH  register at i_Peek_Addr, registered
- o_Reg_WriteStrobe  out  1  one-clk pulse per committed write
- o_Reg_WriteAddr  out  CMDLENGTH  address of the last committed write
- o_Reg_WriteData  out  CMDLENGTH  data of the last committed write
- o_Busy  out  1  high while synchronized CS is low
- o_Cmd_Error  out  1  sticky; set on unknown instruction, cleared at next CS falling edge

## Operation
- Inputs pass through SYNC_STAGES flops; SCLK rise/fall and CS fall/rise are single-clk pulses from the last two synchronized samples.
- Mode 0: MOSI sampled on SCLK rise; MISO updated on SCLK fall. 3-bit bit counter, reset at every CS fall.
- States: IDLE, INSTR, ADDR, DATA, IGNORE.
- IDLE: CS fall -> INSTR, clears o_Cmd_Error.
- INSTR: on 8th rise, 0x0A (write) or 0x0B (read) -> ADDR; any other value -> IGNORE, o_Cmd_Error=1.
- ADDR: on 8th rise latch address into pointer -> DATA. For read, load MISO shift register with reg[pointer].
- DATA, write: on each 8th rise, commit byte to reg[pointer], pulse strobe, increment pointer.
- DATA, read: on each 8th rise, increment pointer and reload shift register with reg[new pointer] (burst read).
- Pointer is CMDLENGTH bits, wraps 0xFF -> 0x00.
- IGNORE: shifts nothing, MISO=0, until CS rise.
- CS rise in any state -> IDLE same clk; a partial byte is discarded with no write and no pointer change.
- Register file reset values: reg[0x00]=0xAD, reg[0x01]=0x1D, reg[0x02]=0xF2, all others 0x00.
- Addresses 0x00-0x02 are read-only: writes are ignored, no strobe.
- Addresses >= REG_COUNT read 0x00; writes ignored, no strobe.
- Soft reset: a write of 0x52 to 0x1F restores all reset values one clk after the commit. The strobe still pulses; reg[0x1F] stays 0x00.
- o_SPI_Miso is 0 whenever CS is high and during INSTR/ADDR.

## Timing
- Reset values: o_SPI_Miso=0, o_Peek_Data=0x00, o_Reg_WriteStrobe=0, o_Reg_WriteAddr=0x00, o_Reg_WriteData=0x00, o_Busy=0, o_Cmd_Error=0, state IDLE, register file at reset values.
- Edge-to-action latency: SYNC_STAGES+1 clk from the pin edge to the internal action.
- MISO MSB is valid at the SCLK fall following the 8th address rise, i.e. before the first data rise.
- Write commit, strobe, addr/data outputs: SYNC_STAGES+1 clk after the 8th rise at the pin. The strobe is exactly 1 clk wide.
- o_Peek_Data: 1 clk latency. When a write and a peek hit the same address in the same clk, the peek returns the old value.
- Simultaneous 8th-rise and CS-rise pulses cannot occur, because they come from distinct pin edges. CS rise takes precedence if the synchronized versions coincide.
- Reset asserted mid-transaction: immediate return to reset values. The first transaction after release starts only on a fresh CS fall.

## Test plan
- Read 0x0B,0x00 plus one dummy byte -> MISO returns 0xAD; o_Cmd_Error=0; no strobe.
- Write 0x0A,0x2D,0x02 -> one strobe, addr 0x2D, data 0x02; then peek 0x2D -> 0x02; read-back over SPI -> 0x02.
- Burst read 0x0B,0x00 plus three dummy bytes -> 0xAD,0x1D,0xF2.
- Burst write 0x0A,0xFF,0x11,0x22 -> writes to 0xFF and 0x00 are both ignored (out of range and read-only), strobe count 0, pointer wraps to 0x00.
- Instruction 0x55 -> o_Cmd_Error=1, MISO=0, no strobe. Next valid transaction clears the error.
- Write to 0x2C aborted by CS high after 4 data bits -> no strobe, reg[0x2C] unchanged. Then write 0x52 to 0x1F -> reg[0x2D] and reg[0x2C] return to 0x00.
